// File: rtl/urv_dmem_responder.sv
// Data-memory responder for the uRV core: serves a local byte-writable RAM
// with a fixed one-cycle latency and forwards upper-half addresses to a classic
// Wishbone master port with a bounded wait for the slave.
module urv_dmem_responder #(
    parameter int unsigned RAM_WORDS = 4096,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err_o
);

    localparam int unsigned AW       = $clog2(RAM_WORDS);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_BUS
    } state_e;

    // Source for the load-data register in the next cycle.
    typedef enum logic [1:0] {
        D_HOLD,
        D_RAM,
        D_WB,
        D_ERR
    } dsel_e;

    logic [31:0]   mem [RAM_WORDS];
    logic [AW-1:0] ram_idx;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        load_done_q, load_done_d;
    logic        store_done_q, store_done_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] data_l_q;
    logic [31:0] wb_adr_q, wb_dat_q;
    logic [3:0]  wb_sel_q;
    logic        wb_we_q;

    dsel_e dsel;
    logic  wb_capture;
    logic  ram_we;
    logic  req;
    logic  is_store;

    // Higher address bits are ignored so local addresses wrap modulo the RAM.
    assign ram_idx  = dm_addr_i[AW+1:2];
    assign req      = dm_load_i | dm_store_i;
    // A simultaneous load and store is handled as a store.
    assign is_store = dm_store_i;

    // Next-state, done pulses, load-data source and Wishbone capture.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        wb_cyc_d     = wb_cyc_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        bus_err_d    = bus_err_q;
        dsel         = D_HOLD;
        wb_capture   = 1'b0;
        ram_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (dm_load_i && dm_store_i) begin
                        bus_err_d = 1'b1;
                    end
                    if (dm_addr_i[31]) begin
                        state_d    = S_BUS;
                        cnt_d      = '0;
                        wb_cyc_d   = 1'b1;
                        wb_capture = 1'b1;
                    end else if (is_store) begin
                        ram_we       = 1'b1;
                        store_done_d = 1'b1;
                    end else begin
                        load_done_d = 1'b1;
                        dsel        = D_RAM;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 16'd1;
                // Error beats ack; the timeout only fires when no ack arrives.
                if (wb_err_i || (!wb_ack_i && cnt_q == TMO_LAST)) begin
                    state_d      = S_IDLE;
                    wb_cyc_d     = 1'b0;
                    bus_err_d    = 1'b1;
                    store_done_d = wb_we_q;
                    load_done_d  = !wb_we_q;
                    if (!wb_we_q) begin
                        dsel = D_ERR;
                    end
                end else if (wb_ack_i) begin
                    state_d      = S_IDLE;
                    wb_cyc_d     = 1'b0;
                    store_done_d = wb_we_q;
                    load_done_d  = !wb_we_q;
                    if (!wb_we_q) begin
                        dsel = D_WB;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                wb_cyc_d = 1'b0;
            end
        endcase
    end

    // State, control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wb_cyc_q     <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
            data_l_q     <= '0;
            wb_adr_q     <= '0;
            wb_dat_q     <= '0;
            wb_sel_q     <= '0;
            wb_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_cyc_q     <= wb_cyc_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            bus_err_q    <= bus_err_d;
            if (wb_capture) begin
                wb_adr_q <= dm_addr_i & ~32'h3;
                wb_dat_q <= dm_data_s_i;
                wb_sel_q <= is_store ? dm_data_select_i : 4'b1111;
                wb_we_q  <= is_store;
            end
            case (dsel)
                D_RAM:   data_l_q <= mem[ram_idx];
                D_WB:    data_l_q <= wb_dat_i;
                D_ERR:   data_l_q <= ERR_DATA;
                default: data_l_q <= data_l_q;
            endcase
        end
    end

    // Byte-lane writes into the local RAM.
    always_ff @(posedge clk_i) begin
        // NOTE: RAM contents are deliberately left out of reset so the array maps onto block RAM.
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_data_select_i[b]) begin
                    mem[ram_idx][b*8 +: 8] <= dm_data_s_i[b*8 +: 8];
                end
            end
        end
    end

    assign dm_ready_o      = (state_q == S_IDLE);
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign wb_adr_o        = wb_adr_q;
    assign wb_dat_o        = wb_dat_q;
    assign wb_sel_o        = wb_sel_q;
    assign wb_we_o         = wb_we_q;
    assign wb_cyc_o        = wb_cyc_q;
    assign wb_stb_o        = wb_cyc_q;
    assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_urv_dmem_responder.sv
// Directed bench for urv_dmem_responder: local RAM path, external Wishbone
// path with wait states, timeout, error, ignored requests and reset abort.
module tb_urv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        bus_err_o;

    int tests = 0;
    int fails = 0;

    urv_dmem_responder #(
        .RAM_WORDS(256),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .dm_addr_i       (dm_addr_i),
        .dm_data_s_i     (dm_data_s_i),
        .dm_data_select_i(dm_data_select_i),
        .dm_load_i       (dm_load_i),
        .dm_store_i      (dm_store_i),
        .dm_ready_o      (dm_ready_o),
        .dm_data_l_o     (dm_data_l_o),
        .dm_load_done_o  (dm_load_done_o),
        .dm_store_done_o (dm_store_done_o),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_o        (wb_sel_o),
        .wb_we_o         (wb_we_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_dat_i        (wb_dat_i),
        .wb_ack_i        (wb_ack_i),
        .wb_err_i        (wb_err_i),
        .bus_err_o       (bus_err_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dm_load_i        = 1'b0;
        dm_store_i       = 1'b0;
        dm_addr_i        = '0;
        dm_data_s_i      = '0;
        dm_data_select_i = '0;
        wb_ack_i         = 1'b0;
        wb_err_i         = 1'b0;
        wb_dat_i         = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic local_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = s;
        dm_store_i = 1'b1; dm_load_i = 1'b0;
        tick();
        dm_store_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (dm_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b exp 1", dm_ready_o); end
        tests++; if ({dm_load_done_o, dm_store_done_o} !== 2'b00) begin fails++; $display("FAIL reset_done: got %b exp 00", {dm_load_done_o, dm_store_done_o}); end
        tests++; if (dm_data_l_o !== 32'h0) begin fails++; $display("FAIL reset_data: got %h exp 0", dm_data_l_o); end
        tests++; if ({wb_cyc_o, wb_stb_o, wb_we_o, bus_err_o} !== 4'b0000) begin fails++; $display("FAIL reset_wb: got %b exp 0000", {wb_cyc_o, wb_stb_o, wb_we_o, bus_err_o}); end
    endtask

    task automatic test_local_store_load();
        local_store(32'h100, 32'h11223344, 4'b1111);
        tests++; if (dm_store_done_o !== 1'b1) begin fails++; $display("FAIL t1_preset_done: got %0b exp 1", dm_store_done_o); end
        local_store(32'h100, 32'hA5A5A5A5, 4'b0010);
        tests++; if ({dm_store_done_o, dm_load_done_o} !== 2'b10) begin fails++; $display("FAIL t1_store_done: got %b exp 10", {dm_store_done_o, dm_load_done_o}); end
        dm_addr_i = 32'h100; dm_load_i = 1'b1;
        tick();
        dm_load_i = 1'b0;
        tests++; if ({dm_load_done_o, dm_store_done_o} !== 2'b10) begin fails++; $display("FAIL t1_load_done: got %b exp 10", {dm_load_done_o, dm_store_done_o}); end
        tests++; if (dm_data_l_o !== 32'h1122A544) begin fails++; $display("FAIL t1_load_data: got %h exp 1122a544", dm_data_l_o); end
        tick();
        tests++; if (dm_load_done_o !== 1'b0) begin fails++; $display("FAIL t1_done_single: got %0b exp 0", dm_load_done_o); end
        tests++; if (dm_data_l_o !== 32'h1122A544) begin fails++; $display("FAIL t1_data_hold: got %h exp 1122a544", dm_data_l_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] exp_d [4];
        addrs = '{32'h0, 32'h4, 32'h8, 32'h400};
        exp_d = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h01010101};
        local_store(32'h0, 32'h01010101, 4'b1111);
        local_store(32'h4, 32'h02020202, 4'b1111);
        local_store(32'h8, 32'h03030303, 4'b1111);
        dm_load_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (dm_ready_o !== 1'b1) begin fails++; $display("FAIL t2_ready[%0d]: got %0b exp 1", i, dm_ready_o); end
            dm_addr_i = addrs[i];
            tick();
            tests++; if (dm_load_done_o !== 1'b1 || dm_data_l_o !== exp_d[i]) begin
                fails++; $display("FAIL t2_load[%0d]: got done=%0b data=%h exp done=1 data=%h", i, dm_load_done_o, dm_data_l_o, exp_d[i]);
            end
        end
        dm_load_i = 1'b0;
        tick();
        tests++; if (dm_load_done_o !== 1'b0) begin fails++; $display("FAIL t2_done_end: got %0b exp 0", dm_load_done_o); end
    endtask

    task automatic test_ext_load();
        int busy = 0;
        dm_addr_i = 32'h80000010; dm_load_i = 1'b1;
        tick();
        dm_load_i = 1'b0;
        tests++; if (wb_adr_o !== 32'h80000010 || wb_we_o !== 1'b0 || wb_sel_o !== 4'b1111) begin
            fails++; $display("FAIL t3_wb_req: got adr=%h we=%0b sel=%b exp adr=80000010 we=0 sel=1111", wb_adr_o, wb_we_o, wb_sel_o);
        end
        for (int k = 1; k <= 4; k++) begin
            if (dm_ready_o === 1'b0) busy++;
            tests++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin fails++; $display("FAIL t3_cyc[%0d]: got %b exp 11", k, {wb_cyc_o, wb_stb_o}); end
            if (k == 4) begin
                wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
            end
            tick();
        end
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        tests++; if (busy != 4) begin fails++; $display("FAIL t3_busy_cycles: got %0d exp 4", busy); end
        tests++; if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'hCAFEF00D) begin
            fails++; $display("FAIL t3_load: got done=%0b data=%h exp done=1 data=cafef00d", dm_load_done_o, dm_data_l_o);
        end
        tests++; if ({dm_ready_o, wb_cyc_o, bus_err_o} !== 3'b100) begin fails++; $display("FAIL t3_after: got ready/cyc/err=%b exp 100", {dm_ready_o, wb_cyc_o, bus_err_o}); end
        // A request in the done cycle must be accepted straight away.
        dm_addr_i = 32'h4; dm_load_i = 1'b1;
        tick();
        dm_load_i = 1'b0;
        tests++; if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'h02020202) begin
            fails++; $display("FAIL t3_followon: got done=%0b data=%h exp done=1 data=02020202", dm_load_done_o, dm_data_l_o);
        end
    endtask

    task automatic test_timeout();
        dm_addr_i = 32'h80000022; dm_data_s_i = 32'h12345678; dm_data_select_i = 4'b1100;
        dm_store_i = 1'b1;
        tick();
        dm_store_i = 1'b0;
        tests++; if (wb_adr_o !== 32'h80000020 || wb_we_o !== 1'b1 || wb_sel_o !== 4'b1100 || wb_dat_o !== 32'h12345678) begin
            fails++; $display("FAIL t4_wb_req: got adr=%h we=%0b sel=%b dat=%h exp 80000020 1 1100 12345678", wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o);
        end
        for (int k = 1; k <= 8; k++) begin
            tests++; if (wb_cyc_o !== 1'b1 || dm_store_done_o !== 1'b0) begin
                fails++; $display("FAIL t4_wait[%0d]: got cyc=%0b done=%0b exp cyc=1 done=0", k, wb_cyc_o, dm_store_done_o);
            end
            tick();
        end
        tests++; if ({wb_cyc_o, dm_store_done_o, bus_err_o, dm_ready_o} !== 4'b0111) begin
            fails++; $display("FAIL t4_abort: got cyc/done/err/ready=%b exp 0111", {wb_cyc_o, dm_store_done_o, bus_err_o, dm_ready_o});
        end
        dm_addr_i = 32'h100; dm_load_i = 1'b1;
        tick();
        dm_load_i = 1'b0;
        tick();
        tests++; if (bus_err_o !== 1'b1) begin fails++; $display("FAIL t4_sticky: got %0b exp 1", bus_err_o); end
    endtask

    task automatic test_err_and_ignore();
        int extra = 0;
        apply_reset();
        dm_addr_i = 32'h80000040; dm_load_i = 1'b1;
        tick();
        // Load request while busy: must be dropped.
        dm_addr_i = 32'h0;
        tick();
        dm_load_i = 1'b0;
        tests++; if (dm_load_done_o !== 1'b0) begin fails++; $display("FAIL t5_ignored: got %0b exp 0", dm_load_done_o); end
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h55555555;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        tests++; if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'hDEADBEEF || bus_err_o !== 1'b1) begin
            fails++; $display("FAIL t5_err: got done=%0b data=%h err=%0b exp 1 deadbeef 1", dm_load_done_o, dm_data_l_o, bus_err_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (dm_load_done_o === 1'b1 || dm_store_done_o === 1'b1) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL t5_extra_done: got %0d exp 0", extra); end
    endtask

    task automatic test_reset_mid_bus();
        int late = 0;
        apply_reset();
        dm_addr_i = 32'h80000010; dm_load_i = 1'b1;
        tick();
        dm_load_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests++; if ({wb_cyc_o, dm_load_done_o, dm_ready_o} !== 3'b001) begin
            fails++; $display("FAIL t6_abort: got cyc/done/ready=%b exp 001", {wb_cyc_o, dm_load_done_o, dm_ready_o});
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h77777777;
        tick();
        wb_ack_i = 1'b0;
        if (dm_load_done_o === 1'b1) late++;
        tests++; if (late != 0) begin fails++; $display("FAIL t6_late_done: got %0d exp 0", late); end
        dm_addr_i = 32'h100; dm_load_i = 1'b1;
        tick();
        dm_load_i = 1'b0;
        tests++; if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'h1122A544) begin
            fails++; $display("FAIL t6_local: got done=%0b data=%h exp done=1 data=1122a544", dm_load_done_o, dm_data_l_o);
        end
    endtask

    task automatic test_dual_request();
        apply_reset();
        dm_addr_i = 32'h200; dm_data_s_i = 32'h0BADF00D; dm_data_select_i = 4'b1111;
        dm_load_i = 1'b1; dm_store_i = 1'b1;
        tick();
        dm_load_i = 1'b0; dm_store_i = 1'b0;
        tests++; if ({dm_store_done_o, dm_load_done_o, bus_err_o} !== 3'b101) begin
            fails++; $display("FAIL dual_req: got sdone/ldone/err=%b exp 101", {dm_store_done_o, dm_load_done_o, bus_err_o});
        end
        dm_load_i = 1'b1;
        tick();
        dm_load_i = 1'b0;
        tests++; if (dm_data_l_o !== 32'h0BADF00D) begin fails++; $display("FAIL dual_readback: got %h exp 0badf00d", dm_data_l_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_local_store_load();
        test_back_to_back();
        test_ext_load();
        test_timeout();
        test_err_and_ignore();
        test_reset_mid_bus();
        test_dual_request();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/urv_dmem_responder.md
Name: urv_dmem_responder

Overview:
- Target side of the uRV core data-memory interface. Accepts the core's single-cycle load/store requests and returns completion pulses plus load data.
- Serves a local byte-writable RAM with fixed 1-cycle latency.
- Forwards requests in the upper half of the address space to a classic Wishbone master port, with variable latency and a timeout.
- Sits between the core's execute/writeback stages and the SoC interconnect.

Parameters:
- RAM_WORDS, 4096, local RAM depth in 32-bit words; power of two.
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i/wb_err_i before aborting; 1..65535.
- ERR_DATA, 32'hDEADBEEF, load data returned on an external error or timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- dm_addr_i  in  32  byte address
- dm_data_s_i  in  32  store data, already lane-replicated by the core
- dm_data_select_i  in  4  byte-lane enables
- dm_load_i  in  1  load request pulse
- dm_store_i  in  1  store request pulse
- dm_ready_o  out  1  responder can accept a request this cycle
- dm_data_l_o  out  32  load data, valid while dm_load_done_o=1
- dm_load_done_o  out  1  load complete pulse
- dm_store_done_o  out  1  store complete pulse
- wb_adr_o  out  32  Wishbone address (word aligned, bits[1:0]=0)
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte select
- wb_we_o  out  1  Wishbone write enable
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error
- bus_err_o  out  1  sticky flag: external error or timeout seen; cleared only by reset

Behaviour:
- Reset values: dm_ready_o=1, dm_load_done_o=0, dm_store_done_o=0, dm_data_l_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, bus_err_o=0, timeout counter=0. RAM contents are not reset.
- Acceptance: a request is accepted on a rising edge where dm_ready_o=1 and (dm_load_i or dm_store_i) is high.
  - Requests made while dm_ready_o=0 are ignored; no done pulse is generated for them.
  - dm_load_i and dm_store_i both high: treated as a store; bus_err_o is set.
- Decode: dm_addr_i[31]=0 selects local RAM; dm_addr_i[31]=1 selects external.
  - Local word index = dm_addr_i[log2(RAM_WORDS)+1:2]. Higher address bits are ignored, so addresses alias (wrap) modulo the RAM size.
- FSM state IDLE (local path):
  - dm_ready_o=1.
  - Local store: lanes with dm_data_select_i[n]=1 are written on the acceptance edge; dm_store_done_o=1 for exactly the next cycle.
  - Local load: full word read; dm_data_l_o is driven and dm_load_done_o=1 for exactly the next cycle.
  - Back-to-back local requests are sustained at one per cycle.
- IDLE to BUS on an accepted external request:
  - wb_adr_o = {addr[31:2],2'b00}, wb_dat_o = data, wb_sel_o = select (loads: 4'b1111), wb_we_o = store.
  - wb_cyc_o=wb_stb_o=1 from the cycle after acceptance.
  - Counter cleared.
- State BUS:
  - dm_ready_o=0. wb signals are held stable. Counter increments each cycle.
  - wb_ack_i=1: drop cyc/stb on the next edge; go to IDLE. Emit the done pulse the next cycle; for loads, dm_data_l_o = wb_dat_i sampled at ack.
  - wb_err_i=1, or counter reaches TIMEOUT without ack: drop cyc/stb; go to IDLE. Emit the done pulse; load data = ERR_DATA; set bus_err_o.
  - ack and err in the same cycle: err wins.
- Done pulse and dm_ready_o=1 coincide in the cycle after ack, so the next request can be accepted in that cycle.
- Exactly one done pulse is emitted per accepted request. Done pulses are always single-cycle.
- dm_data_l_o holds its last value when no load is completing.
- Reset mid-transaction: cyc/stb drop at the reset edge, no done pulse is emitted, and the FSM goes to IDLE.

Test Plan:
1. Local store addr 0x100, data 0xA5A5A5A5, sel 4'b0010, after the word was preset to 0x11223344 -> store_done one cycle later; subsequent load of 0x100 returns 0x1122A544 with load_done exactly one cycle after the request.
2. Back-to-back local loads of 0x0, 0x4, 0x8 in consecutive cycles -> three consecutive load_done pulses with the matching data. dm_ready_o stays 1 throughout. An address of RAM_WORDS*4 returns the word at 0x0.
3. External load 0x80000010, slave acks after 3 wait states with 0xCAFEF00D -> wb_adr_o=0x80000010, wb_we_o=0. dm_ready_o=0 for 4 cycles. load_done with 0xCAFEF00D. bus_err_o stays 0.
4. External store 0x80000022, sel 4'b1100, slave never responds, TIMEOUT=8 -> cyc drops after 8 cycles in BUS; store_done pulse; bus_err_o=1 and stays 1 through later good transactions.
5. External load with wb_err_i and wb_ack_i both high at the same cycle -> load data 0xDEADBEEF, bus_err_o=1. A load request issued during BUS is ignored (no extra done pulse).
6. Assert rst_i in the 2nd BUS cycle of an external load -> wb_cyc_o=0 the next cycle, no load_done, dm_ready_o=1. A following local load completes normally.
